// File: rtl/cn_pkg.sv
// Shared CryptoNight core definitions: scratchpad geometry, requester IDs and
// the scratchpad arbiter state encoding.
package cn_pkg;

  localparam int SP_ADDR_WIDTH = 5;
  localparam int SP_DATA_WIDTH = 128;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_e;

endpackage

// File: rtl/spram.sv
// Single-port scratchpad RAM with a registered read port: data for a read
// issued in cycle N appears on dout in cycle N+1.
module spram #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) mem[addr] <= din;
      else    dout_q    <= mem[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/spram_arb2.sv
// Two-port round-robin arbiter with bounded lock in front of the scratchpad.
// Grants are combinational; read data returns one cycle after the grant.
module spram_arb2
  import cn_pkg::*;
#(
  parameter int ADDR_WIDTH = SP_ADDR_WIDTH,
  parameter int DATA_WIDTH = SP_DATA_WIDTH,
  parameter int MAX_LOCK   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  arb_state_e            state_q, state_d;
  port_e                 last_q, last_d;
  logic [3:0]            lockCnt_q, lockCnt_d;
  logic                  aRvalid_q, bRvalid_q;
  logic [ADDR_WIDTH-1:0] addrHold_q;
  logic                  grantA, grantB, lockOk;
  logic                  ramCs, ramWe;
  logic [ADDR_WIDTH-1:0] ramAddr;
  logic [DATA_WIDTH-1:0] ramDin, ramDout;

  // In a lock only the owner can be granted; otherwise ties go to the port not granted last.
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    case (state_q)
      LOCK_A: grantA = a_req;
      LOCK_B: grantB = b_req;
      default: begin
        if (a_req && b_req) begin
          grantA = (last_q == PORT_B);
          grantB = (last_q == PORT_A);
        end else begin
          grantA = a_req;
          grantB = b_req;
        end
      end
    endcase
    if (rst) begin
      grantA = 1'b0;
      grantB = 1'b0;
    end
  end

  // lockCnt_q counts grants already taken in the current lock run (0 in ARB).
  assign lockOk = (int'(lockCnt_q) + 1) < MAX_LOCK;

  always_comb begin
    state_d   = ARB;
    lockCnt_d = '0;
    last_d    = last_q;
    if (grantA)      last_d = PORT_A;
    else if (grantB) last_d = PORT_B;
    if (lockOk && ((grantA && a_lock) || (grantB && b_lock))) begin
      state_d   = grantA ? LOCK_A : LOCK_B;
      lockCnt_d = lockCnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      last_q     <= PORT_B;
      lockCnt_q  <= '0;
      aRvalid_q  <= 1'b0;
      bRvalid_q  <= 1'b0;
      addrHold_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lockCnt_q  <= lockCnt_d;
      aRvalid_q  <= grantA & ~a_we;
      bRvalid_q  <= grantB & ~b_we;
      addrHold_q <= ramAddr;
    end
  end

  // The address bus parks on the last granted address so it does not toggle when idle.
  assign ramCs   = grantA | grantB;
  assign ramWe   = grantA ? a_we : (grantB & b_we);
  assign ramAddr = grantA ? a_addr : (grantB ? b_addr : addrHold_q);
  assign ramDin  = grantB ? b_wdata : a_wdata;

  spram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) uRam (
    .clk (clk),
    .cs  (ramCs),
    .we  (ramWe),
    .addr(ramAddr),
    .din (ramDin),
    .dout(ramDout)
  );

  assign a_gnt    = grantA;
  assign b_gnt    = grantB;
  assign a_rvalid = aRvalid_q;
  assign b_rvalid = bRvalid_q;
  assign a_rdata  = ramDout;
  assign b_rdata  = ramDout;

endmodule

// File: tb/tb_spram_arb2.sv
// Self-checking bench for spram_arb2: per-cycle expected grants plus a
// scoreboard of expected read returns checked as rvalid arrives.
module tb_spram_arb2;

  localparam int AW = 5;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sbQueue[$];
  logic [DW-1:0] model [32];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  spram_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, observed, expected);
    end
  endtask

  // Read-return monitor: rvalid must match the scoreboard head due this cycle.
  always @(negedge clk) begin
    logic expA, expB;
    expA = 1'b0;
    expB = 1'b0;
    if (sbQueue.size() > 0 && sbQueue[0].due == cyc) begin
      expA = (sbQueue[0].port == 1'b0);
      expB = (sbQueue[0].port == 1'b1);
    end
    checkOutput("a_rvalid", DW'(a_rvalid), DW'(expA));
    checkOutput("b_rvalid", DW'(b_rvalid), DW'(expB));
    if (expA && a_rvalid) checkOutput("a_rdata", a_rdata, sbQueue[0].data);
    if (expB && b_rvalid) checkOutput("b_rdata", b_rdata, sbQueue[0].data);
    if (expA || expB) void'(sbQueue.pop_front());
  end

  // Drives one cycle of requests, checks grants, and updates the model from the expected grants.
  task automatic applyStimulus(input string tag,
                               input logic aR, input logic aW, input logic aL,
                               input logic [AW-1:0] aAd, input logic [DW-1:0] aD,
                               input logic bR, input logic bW, input logic bL,
                               input logic [AW-1:0] bAd, input logic [DW-1:0] bD,
                               input logic expA, input logic expB);
    exp_t e;
    a_req = aR; a_we = aW; a_lock = aL; a_addr = aAd; a_wdata = aD;
    b_req = bR; b_we = bW; b_lock = bL; b_addr = bAd; b_wdata = bD;
    @(negedge clk);
    checkOutput({tag, ".a_gnt"}, DW'(a_gnt), DW'(expA));
    checkOutput({tag, ".b_gnt"}, DW'(b_gnt), DW'(expB));
    if (expA) begin
      if (aW) model[aAd] = aD;
      else begin
        e.port = 1'b0; e.data = model[aAd]; e.due = cyc + 1;
        sbQueue.push_back(e);
      end
    end
    if (expB) begin
      if (bW) model[bAd] = bD;
      else begin
        e.port = 1'b1; e.data = model[bAd]; e.due = cyc + 1;
        sbQueue.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Holds reset with both ports requesting; no grant may be given and pending reads are dropped.
  task automatic applyReset(input int nCycles);
    rst = 1'b1;
    sbQueue.delete();
    a_req = 1'b1; a_we = 1'b0; a_lock = 1'b1; a_addr = '0; a_wdata = '0;
    b_req = 1'b1; b_we = 1'b0; b_lock = 1'b1; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < nCycles; i++) begin
      @(negedge clk);
      checkOutput("rst.a_gnt", DW'(a_gnt), '0);
      checkOutput("rst.b_gnt", DW'(b_gnt), '0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
  endtask

  localparam logic [DW-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [DW-1:0] PAT_B7 = {4{32'h7B7B_0007}};
  localparam logic [DW-1:0] PAT_09 = {4{32'h0909_C0DE}};

  initial begin
    int aPtr, bPtr;
    logic [DW-1:0] z;
    z = '0;
    applyReset(2);

    // A writes then reads address 3
    applyStimulus("wrA3", 1, 1, 0, 5'd3, PAT_A5, 0, 0, 0, 5'd0, z, 1, 0);
    applyStimulus("rdA3", 1, 0, 0, 5'd3, z,      0, 0, 0, 5'd0, z, 1, 0);

    for (int i = 0; i < 8; i++) begin
      if (i != 3)
        applyStimulus("preload", 1, 1, 0, AW'(i), {4{32'hC0DE_0000 + 32'(i)}},
                      0, 0, 0, 5'd0, z, 1, 0);
    end
    applyStimulus("wrB8", 0, 0, 0, 5'd0, z, 1, 1, 0, 5'd8, {4{32'h8888_0008}}, 0, 1);

    // Contention: grants alternate starting with A
    aPtr = 0;
    bPtr = 4;
    for (int i = 0; i < 6; i++) begin
      applyStimulus("alt", 1, 0, 0, AW'(aPtr), z, 1, 0, 0, AW'(bPtr), z,
                    (i % 2) == 0, (i % 2) == 1);
      if ((i % 2) == 0) aPtr++;
      else bPtr++;
    end

    // B read-modify-write under lock while A keeps requesting
    applyStimulus("setLastA", 1, 0, 0, 5'd1, z, 0, 0, 0, 5'd0, z, 1, 0);
    applyStimulus("rmwRd",    1, 0, 0, 5'd2, z, 1, 0, 1, 5'd7, z, 0, 1);
    applyStimulus("rmwWr",    1, 0, 0, 5'd2, z, 1, 1, 0, 5'd7, PAT_B7, 0, 1);
    applyStimulus("rmwA",     1, 0, 0, 5'd2, z, 1, 0, 0, 5'd7, z, 1, 0);
    applyStimulus("rmwChk",   0, 0, 0, 5'd0, z, 1, 0, 0, 5'd7, z, 0, 1);

    // Lock limit: B gets 4 grants, then A one, then B again
    applyStimulus("setLastA", 1, 0, 0, 5'd1, z, 0, 0, 0, 5'd0, z, 1, 0);
    for (int i = 0; i < 10; i++)
      applyStimulus("lockLim", 1, 0, 0, 5'd6, z, 1, 0, 1, 5'd5, z,
                    (i % 5) == 4, (i % 5) != 4);

    // Reset in LOCK_A right after a read grant
    applyStimulus("lkWr9", 1, 1, 1, 5'd9, PAT_09, 0, 0, 0, 5'd0, z, 1, 0);
    applyStimulus("lkRd2", 1, 0, 1, 5'd2, z,      0, 0, 0, 5'd0, z, 1, 0);
    applyReset(2);
    applyStimulus("postTie", 1, 0, 0, 5'd9, z, 1, 0, 0, 5'd2, z, 1, 0);
    applyStimulus("postB",   0, 0, 0, 5'd0, z, 1, 0, 0, 5'd2, z, 0, 1);

    // A locks then drops its request
    applyStimulus("lkA",    1, 0, 1, 5'd0, z, 0, 0, 0, 5'd1, z, 1, 0);
    applyStimulus("dropA",  0, 0, 0, 5'd0, z, 1, 0, 0, 5'd1, z, 0, 0);
    applyStimulus("afterB", 0, 0, 0, 5'd0, z, 1, 0, 0, 5'd1, z, 0, 1);

    applyStimulus("idle", 0, 0, 0, 5'd0, z, 0, 0, 0, 5'd0, z, 0, 0);
    applyStimulus("idle", 0, 0, 0, 5'd0, z, 0, 0, 0, 5'd0, z, 0, 0);
    checkOutput("sbEmpty", DW'(sbQueue.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
